// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter in the clk_10M domain.
// Producers push bytes into a small FIFO over valid/ready.
// A baud-timed shift FSM drains the FIFO onto txd, LSB first.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_10M,
  input  logic                          reset_of_clk10M,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // Bit period in clock cycles, rounded to nearest.
  localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [CW-1:0]    BAUD_LAST  = CW'(DIV - 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    head;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic push;
  logic pop;
  logic baud_end;

  assign wr_ready = (fifo_count != COUNT_FULL);
  assign push     = wr_valid && wr_ready;
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign head     = mem[rd_ptr];
  // A pop only ever happens when the FSM is ready to start a frame and data is queued.
  assign pop      = (fifo_count != '0) &&
                    ((state == IDLE) || ((state == STOP) && baud_end));
  assign busy     = (state != IDLE) || (fifo_count != '0);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_10M) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; push and pop on the same edge leave the count unchanged.
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame FSM: drives the registered txd line and chains frames back-to-back from STOP.
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shreg <= head;
            txd   <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            txd      <= shreg[0];
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd   <= ^shreg;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              txd     <= shreg[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= head;
              txd   <= 1'b0;
              state <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          txd      <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed self-checking bench for uart_tx_buffered.
// Runs with DIV=10 (10 MHz clock, 1 Mbaud) and a 4-entry FIFO.
// A background monitor decodes txd into bytes and frame start cycles.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * DIV;

  logic       clk_10M = 1'b0;
  logic       reset_of_clk10M;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rst_cnt  = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic       slot9_val;

  uart_tx_buffered #(
    .CLK_FREQ  (10000000),
    .BAUD      (1000000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_10M        (clk_10M),
    .reset_of_clk10M(reset_of_clk10M),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .txd            (txd),
    .busy           (busy),
    .fifo_count     (fifo_count)
  );

  // 10 MHz clock
  always #50 clk_10M = ~clk_10M;

  // Cycle counter used to timestamp events
  always @(posedge clk_10M) cyc <= cyc + 1;

  // Count reset pulses so the monitor can discard aborted frames
  always @(posedge reset_of_clk10M) rst_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_10M);
    #1;
  endtask

  function automatic logic expBit(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] rxAt(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  // Push one byte, holding valid until the DUT accepts it (bounded)
  task automatic applyStimulus(input logic [7:0] d);
    logic acc;
    int   n;
    wr_data  = d;
    wr_valid = 1'b1;
    n = 0;
    do begin
      acc = wr_ready;
      step();
      n++;
    end while (!acc && n < 2000);
    wr_valid = 1'b0;
    checkOutput("push_accepted", {31'h0, acc}, 32'h1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    step();
    checkOutput("wait_idle", {31'h0, busy}, 32'h0);
  endtask

  // Push into an idle block and compare txd against the expected frame every cycle
  task automatic runFrameCheck(input logic [7:0] d);
    int t0;
    int fall;
    int n;
    int errs;
    t0 = cyc;
    applyStimulus(d);
    n = 0;
    while (txd !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    fall = cyc;
    checkOutput("latency", fall - t0, 2);
    errs = 0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (k > 0) step();
      if (txd !== expBit(d, k / DIV)) errs++;
      if (k == 9 * DIV) slot9_val = txd;
      if (k == FRAME_CYC - 1) checkOutput("busy_last_cycle", {31'h0, busy}, 32'h1);
    end
    step();
    checkOutput("busy_end", {31'h0, busy}, 32'h0);
    checkOutput("frame_bits", errs, 0);
  endtask

  // Background line decoder: samples each bit at its middle
  initial begin : monitor
    logic [7:0] b;
    logic       s0, stp;
    int         st, r0;
`ifdef UART_TX_PARITY_EN
    logic       par;
`endif
    forever begin
      do begin
        @(posedge clk_10M);
        #2;
      end while (txd !== 1'b0);
      st = cyc;
      r0 = rst_cnt;
      repeat (DIV / 2) @(posedge clk_10M);
      #2;
      s0 = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk_10M);
        #2;
        b[i] = txd;
      end
`ifdef UART_TX_PARITY_EN
      repeat (DIV) @(posedge clk_10M);
      #2;
      par = txd;
`endif
      repeat (DIV) @(posedge clk_10M);
      #2;
      stp = txd;
      if (rst_cnt == r0) begin
        checkOutput("mon_start_bit", {31'h0, s0}, 32'h0);
        checkOutput("mon_stop_bit", {31'h0, stp}, 32'h1);
`ifdef UART_TX_PARITY_EN
        checkOutput("mon_parity", {31'h0, par}, {31'h0, ^b});
`endif
        rx_q.push_back(b);
        start_q.push_back(st);
      end
    end
  end

  // Watchdog: ends the run if something stalls beyond every bounded wait
  initial begin
    #6000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0] bytes6 [6];
    int         acc_cyc [6];
    int         base, sbase, a0, n, lows, fall;
    logic       acc;

    bytes6 = '{8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86};

    // Reset values
    reset_of_clk10M = 1'b1;
    wr_valid        = 1'b0;
    wr_data         = 8'h00;
    repeat (3) step();
    checkOutput("reset_txd", {31'h0, txd}, 32'h1);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_ready", {31'h0, wr_ready}, 32'h1);
    checkOutput("reset_count", {29'h0, fifo_count}, 32'h0);
    reset_of_clk10M = 1'b0;
    repeat (2) step();

    // Single byte 0x55
    $display("[TB] single frame 0x55");
    runFrameCheck(8'h55);
    checkOutput("rx_55", rxAt(0), 32'h55);

    // Two consecutive pushes: back-to-back frames
    $display("[TB] back-to-back 0xA3 0x0F");
    waitIdle();
    base  = rx_q.size();
    sbase = start_q.size();
    wr_valid = 1'b1;
    wr_data  = 8'hA3;
    step();
    wr_data  = 8'h0F;
    step();
    wr_valid = 1'b0;
    n = 0;
    while (rx_q.size() < base + 2 && n < 500) begin
      step();
      n++;
    end
    checkOutput("b2b_rx_count", rx_q.size(), base + 2);
    checkOutput("b2b_rx0", rxAt(base), 32'hA3);
    checkOutput("b2b_rx1", rxAt(base + 1), 32'h0F);
    if (start_q.size() >= sbase + 2)
      checkOutput("b2b_period", start_q[sbase+1] - start_q[sbase], FRAME_CYC);
    else
      checkOutput("b2b_period", 32'hFFFF_FFFF, FRAME_CYC);

    // Hold valid with six bytes: FIFO fills, sixth waits for the end of frame 1
    $display("[TB] fill FIFO with six bytes");
    waitIdle();
    base = rx_q.size();
    a0   = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = bytes6[i];
      n = 0;
      do begin
        acc = wr_ready;
        if (i == 5 && cyc == a0 + FRAME_CYC + 1) begin
          checkOutput("full_pop_count", {29'h0, fifo_count}, 32'h3);
          checkOutput("full_pop_ready", {31'h0, wr_ready}, 32'h1);
        end
        step();
        n++;
      end while (!acc && n < 2000);
      acc_cyc[i] = cyc;
      if (i == 0) a0 = cyc;
      if (i == 1) checkOutput("pop_after_first", {31'h0, txd}, 32'h0);
      if (i == 4) begin
        checkOutput("full_count", {29'h0, fifo_count}, 32'h4);
        checkOutput("full_ready", {31'h0, wr_ready}, 32'h0);
      end
    end
    wr_valid = 1'b0;
    checkOutput("fifth_accept", acc_cyc[4] - a0, 4);
    checkOutput("sixth_accept", acc_cyc[5] - a0, FRAME_CYC + 2);
    n = 0;
    while (rx_q.size() < base + 6 && n < 8 * FRAME_CYC) begin
      step();
      n++;
    end
    checkOutput("fill_rx_count", rx_q.size(), base + 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("fill_rx%0d", i), rxAt(base + i), {24'h0, bytes6[i]});

    // Reset mid-frame with two bytes queued
    $display("[TB] reset mid-frame");
    waitIdle();
    base = rx_q.size();
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    step();
    fall = cyc + 1;
    wr_data  = 8'h11;
    step();
    wr_data  = 8'h22;
    step();
    wr_valid = 1'b0;
    while (cyc < fall + 35) step();
    checkOutput("pre_reset_txd", {31'h0, txd}, 32'h0);
    checkOutput("pre_reset_count", {29'h0, fifo_count}, 32'h2);
    #20;
    reset_of_clk10M = 1'b1;
    #1;
    checkOutput("abort_txd", {31'h0, txd}, 32'h1);
    checkOutput("abort_count", {29'h0, fifo_count}, 32'h0);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    step();
    reset_of_clk10M = 1'b0;
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (txd !== 1'b1) lows++;
    end
    checkOutput("abort_line_quiet", lows, 0);
    checkOutput("abort_no_rx", rx_q.size(), base);
    checkOutput("abort_busy_after", {31'h0, busy}, 32'h0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two
    $display("[TB] parity frames");
    waitIdle();
    runFrameCheck(8'h07);
    checkOutput("parity_07", {31'h0, slot9_val}, 32'h1);
    waitIdle();
    runFrameCheck(8'h03);
    checkOutput("parity_03", {31'h0, slot9_val}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
